// File: rtl/shifter_pkg.sv
// Shared types for the sequential shifter: op encoding, FSM states, width sanity helper.
// Pure declarations; no logic, no latency or backpressure of its own.
package shifter_pkg;

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_SRA = 2'b10,
    OP_ROR = 2'b11
  } shift_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } shift_state_t;

  function automatic bit is_pow2_ge2(input int w);
    return (w >= 2) && ((w & (w - 1)) == 0);
  endfunction

endpackage

// File: rtl/shift_stage.sv
// One barrel stage: shift operand by amt when en is set, else pass through.
// Purely combinational; no backpressure. Rotate wrap exists only with SEQ_SHIFTER_ROTATE_EN.
module shift_stage
  import shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  localparam int SHAMT_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0]   operand,
  input  shift_op_t          op,
  input  logic [SHAMT_W-1:0] amt,
  input  logic               en,
  input  logic               fill,
  output logic [WIDTH-1:0]   result
);

  logic [WIDTH-1:0] srl_v;
  logic [WIDTH-1:0] fill_mask;
`ifdef SEQ_SHIFTER_ROTATE_EN
  logic [SHAMT_W:0] rol_amt;
`endif

  always_comb begin
    srl_v     = operand >> amt;
    fill_mask = ~({WIDTH{1'b1}} >> amt);
`ifdef SEQ_SHIFTER_ROTATE_EN
    // amt is never zero when a stage is enabled, so the wrap shift stays below WIDTH
    rol_amt   = (SHAMT_W + 1)'(WIDTH) - {1'b0, amt};
`endif
    result    = operand;
    if (en) begin
      case (op)
        OP_SLL:  result = operand << amt;
        OP_SRL:  result = srl_v;
        OP_SRA:  result = fill ? (srl_v | fill_mask) : srl_v;
`ifdef SEQ_SHIFTER_ROTATE_EN
        OP_ROR:  result = srl_v | (operand << rol_amt);
`else
        OP_ROR:  result = srl_v;
`endif
        default: result = operand;
      endcase
    end
  end

endmodule

// File: rtl/seq_shifter.sv
// Iterative log-stage shifter (SLL/SRL/SRA, ROR under SEQ_SHIFTER_ROTATE_EN); fixed SHAMT_W-cycle latency.
// Accepts only in IDLE; result held in DONE until out_ready, one idle cycle between jobs.
module seq_shifter
  import shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  localparam int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [1:0]         in_op,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               busy
);

  if (!is_pow2_ge2(WIDTH)) begin : g_width_chk
    $error("seq_shifter: WIDTH must be a power of two, 2 or greater");
  end

  localparam logic [SHAMT_W-1:0] K_LAST = SHAMT_W'(SHAMT_W - 1);

  shift_state_t       state_q, state_d;
  logic [SHAMT_W-1:0] k_q, k_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic [SHAMT_W-1:0] shamt_q, shamt_d;
  shift_op_t          op_q, op_d;
  logic               sign_q, sign_d;
  logic [WIDTH-1:0]   out_data_q, out_data_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic               busy_q, busy_d;

  logic [SHAMT_W-1:0] stage_amt;
  logic               stage_en;
  logic [WIDTH-1:0]   stage_res;

  assign stage_amt = SHAMT_W'(1) << k_q;
  assign stage_en  = |(shamt_q & stage_amt);

  shift_stage #(.WIDTH(WIDTH)) u_stage (
    .operand (data_q),
    .op      (op_q),
    .amt     (stage_amt),
    .en      (stage_en),
    .fill    (sign_q),
    .result  (stage_res)
  );

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    data_d     = data_q;
    shamt_d    = shamt_q;
    op_d       = op_q;
    sign_d     = sign_q;
    out_data_d = out_data_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          data_d  = in_data;
          shamt_d = in_shamt;
          op_d    = shift_op_t'(in_op);
          sign_d  = in_data[WIDTH-1];
          k_d     = K_LAST;
          state_d = RUN;
        end
      end
      RUN: begin
        data_d = stage_res;
        if (k_q == '0) begin
          out_data_d = stage_res;
          state_d    = DONE;
        end else begin
          k_d = k_q - SHAMT_W'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          k_d     = K_LAST;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      k_q         <= K_LAST;
      data_q      <= '0;
      shamt_q     <= '0;
      op_q        <= OP_SLL;
      sign_q      <= 1'b0;
      out_data_q  <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      data_q      <= data_d;
      shamt_q     <= shamt_d;
      op_q        <= op_d;
      sign_q      <= sign_d;
      out_data_q  <= out_data_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_seq_shifter.sv
// Scoreboard bench for seq_shifter: driver queues expected results, negedge monitor checks them.
module tb_seq_shifter;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [4:0]  in_shamt;
  logic [1:0]  in_op;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        busy;

  seq_shifter #(.WIDTH(32)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] data;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: compare each new result, its latency, and stability while stalled.
  logic        prev_vld = 1'b0;
  logic [31:0] held;
  always @(negedge clock) begin
    exp_t e;
    if (out_valid && !prev_vld) begin
      if (sb.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_output: got 0x%08h with no request pending (cycle %0d)", out_data, cyc);
      end else begin
        e = sb.pop_front();
        check("result", out_data, e.data);
        check("latency", 32'(cyc - e.acc), 32'd5);
      end
      held = out_data;
    end else if (out_valid && prev_vld) begin
      check("stall_hold", out_data, held);
    end
    prev_vld = out_valid;
  end

  task automatic send(input logic [1:0] op, input logic [31:0] d, input logic [4:0] sh,
                      input logic [31:0] exp, input bit push);
    int n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    check("send_ready", {31'd0, in_ready}, 32'd1);
    if (!in_ready) return;
    in_valid = 1'b1;
    in_op    = op;
    in_data  = d;
    in_shamt = sh;
    @(posedge clock);
    @(negedge clock);
    in_valid = 1'b0;
    if (push) sb.push_back('{exp, cyc});
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || busy) && n < 200) begin
      @(negedge clock);
      n++;
    end
    check("drain_done", {31'd0, (sb.size() == 0) && !busy}, 32'd1);
  endtask

  localparam int NV = 12;
  logic [1:0]  v_op  [NV] = '{2'd2, 2'd0, 2'd1, 2'd0, 2'd1, 2'd2, 2'd3,
                              2'd2, 2'd2, 2'd0, 2'd3, 2'd3};
  logic [31:0] v_dat [NV] = '{32'h80000000, 32'h00000001, 32'hF0000000, 32'h12345678,
                              32'h12345678, 32'h12345678, 32'h12345678, 32'h70000000,
                              32'h80000001, 32'hA5A5A5A5, 32'h12345678, 32'h00000001};
  logic [4:0]  v_sh  [NV] = '{5'd16, 5'd31, 5'd4, 5'd0, 5'd0, 5'd0, 5'd0,
                              5'd4, 5'd31, 5'd5, 5'd8, 5'd1};
`ifdef SEQ_SHIFTER_ROTATE_EN
  logic [31:0] v_exp [NV] = '{32'hFFFF8000, 32'h80000000, 32'h0F000000, 32'h12345678,
                              32'h12345678, 32'h12345678, 32'h12345678, 32'h07000000,
                              32'hFFFFFFFF, 32'hB4B4B4A0, 32'h78123456, 32'h80000000};
`else
  logic [31:0] v_exp [NV] = '{32'hFFFF8000, 32'h80000000, 32'h0F000000, 32'h12345678,
                              32'h12345678, 32'h12345678, 32'h12345678, 32'h07000000,
                              32'hFFFFFFFF, 32'hB4B4B4A0, 32'h00123456, 32'h00000000};
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_shamt  = '0;
    in_op     = '0;
    out_ready = 1'b1;
    repeat (2) @(negedge clock);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    @(negedge clock);

    for (int i = 0; i < NV; i++) send(v_op[i], v_dat[i], v_sh[i], v_exp[i], 1'b1);
    drain();
    @(negedge clock);
    check("idle_hold_data", out_data, v_exp[NV-1]);
    check("idle_in_ready", {31'd0, in_ready}, 32'd1);

    // Stalled result with a competing request waiting on in_valid
    out_ready = 1'b0;
    send(2'd1, 32'h0000FF00, 5'd8, 32'h000000FF, 1'b1);
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clock);
      n++;
    end
    check("stall_reached_done", {31'd0, out_valid}, 32'd1);
    in_valid = 1'b1;
    in_data  = 32'hDEADBEEF;
    in_shamt = 5'd3;
    in_op    = 2'd0;
    for (int i = 0; i < 3; i++) begin
      check("stall_in_ready", {31'd0, in_ready}, 32'd0);
      check("stall_out_valid", {31'd0, out_valid}, 32'd1);
      @(negedge clock);
    end
    out_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    check("hs_out_valid", {31'd0, out_valid}, 32'd0);
    check("hs_in_ready", {31'd0, in_ready}, 32'd1);
    check("hs_no_accept", {31'd0, busy}, 32'd0);
    check("hs_out_data", out_data, 32'h000000FF);
    in_valid = 1'b0;
    drain();

    // Reset on the second RUN cycle discards the job
    send(2'd1, 32'hFFFF0000, 5'd4, 32'h0, 1'b0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_out_data", out_data, 32'd0);
    check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    repeat (8) @(negedge clock);
    send(2'd1, 32'h00000100, 5'd8, 32'h00000001, 1'b1);
    drain();

    check("queue_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/seq_shifter.md
SEQ_SHIFTER -- requirements
Module: seq_shifter

Interface
REQ-001 SHALL provide parameter WIDTH, default 32, datapath width in bits; legal values are powers of two, 2 or greater.
REQ-002 SHALL derive localparam SHAMT_W = $clog2(WIDTH), default 5, shift-amount width and iteration count.
REQ-003 SHALL provide port clock  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL provide port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL provide port in_valid  input  1  request present.
REQ-006 SHALL provide port in_ready  output  1  block can accept a request.
REQ-007 SHALL provide port in_data  input  WIDTH  operand.
REQ-008 SHALL provide port in_shamt  input  SHAMT_W  shift amount, 0..WIDTH-1.
REQ-009 SHALL provide port in_op  input  2  operation: 00 SLL, 01 SRL, 10 SRA, 11 ROR.
REQ-010 SHALL provide port out_valid  output  1  result present.
REQ-011 SHALL provide port out_ready  input  1  consumer accepts the result.
REQ-012 SHALL provide port out_data  output  WIDTH  result.
REQ-013 SHALL provide port busy  output  1  high in any state other than IDLE.

Function
REQ-014 SHALL implement a three-state FSM: IDLE, RUN and DONE.
REQ-015 SHALL drive in_ready high only in IDLE.
REQ-016 SHALL accept a request on any edge where in_valid and in_ready are both high, latching data, shamt and op, setting the stage index to SHAMT_W-1 and entering RUN.
REQ-017 In RUN, on each edge, SHALL apply a shift of 2^k positions when bit k of the latched shamt is set (pass-through otherwise), then decrement k.
REQ-018 SHALL leave RUN for DONE on the edge that processes k = 0.
REQ-019 SHALL use a fixed latency: out_valid rises exactly SHAMT_W edges after the acceptance edge (5 cycles for WIDTH = 32), including when shamt = 0.
REQ-020 SHALL define the stage operations as follows: SLL zero-fills at the LSB end; SRL zero-fills at the MSB end; SRA fills with the original operand bit WIDTH-1; ROR wraps LSBs into the MSBs.
REQ-021 SHALL drive out_valid high only in DONE.
REQ-022 SHALL hold out_data stable while out_valid is high and out_ready is low.
REQ-023 SHALL return from DONE to IDLE on the edge where out_valid and out_ready are both high; a new request is not accepted on that same edge.
REQ-024 SHALL ignore in_valid, in_data, in_shamt and in_op outside IDLE.
REQ-025 SHALL ignore out_ready outside DONE.
REQ-026 SHALL hold out_data at its last result in IDLE and at 0 after reset until the first result.

Reset
REQ-027 On reset high at an edge, SHALL enter IDLE and set out_valid = 0, out_data = 0, busy = 0, in_ready = 1 and the stage index to SHAMT_W-1.
REQ-028 SHALL give reset priority over all other events, including mid-RUN or in DONE with out_ready high; any in-flight operation is discarded with no output.

Configuration
REQ-029 SHALL compile rotate support under macro SEQ_SHIFTER_ROTATE_EN.
REQ-030 With SEQ_SHIFTER_ROTATE_EN defined, SHALL perform op 11 as ROR.
REQ-031 Without SEQ_SHIFTER_ROTATE_EN, SHALL perform op 11 as SRL and synthesise no rotate wrap logic; all other ops are unchanged.

Structure
REQ-032 SHALL place the op encoding (shift_op_t: OP_SLL, OP_SRL, OP_SRA, OP_ROR) and the FSM state type (shift_state_t) in shared package shifter_pkg.
REQ-033 SHALL implement one combinational sub-module, shift_stage, parameterised by WIDTH, taking operand, op, stage amount and enable and producing the stage result; seq_shifter instantiates it once and reuses it every RUN cycle.
REQ-034 SHALL include an elaboration check that WIDTH is a power of two, 2 or greater.

Verification
REQ-035 SHALL cover: SRA, data 0x80000000, shamt 16 -> out_data 0xFFFF8000, out_valid on the 5th edge after acceptance.
REQ-036 SHALL cover: SLL 0x00000001 by 31 -> 0x80000000; SRL 0xF0000000 by 4 -> 0x0F000000.
REQ-037 SHALL cover: shamt 0, any op, data 0x12345678 -> 0x12345678, still 5-cycle latency.
REQ-038 SHALL cover: out_ready held low for 3 cycles in DONE with in_valid high -> out_data stable, in_ready low, no second acceptance, IDLE entered on the handshake edge.
REQ-039 SHALL cover: reset asserted on the 2nd RUN cycle -> next cycle IDLE, out_valid 0, out_data 0, in_ready 1; a following SRL 0x00000100 by 8 -> 0x00000001.
REQ-040 SHALL cover: ROR 0x00000001 by 1 -> 0x80000000 with SEQ_SHIFTER_ROTATE_EN defined, and -> 0x00000000 without it.
